// File: rtl/bus_ram_responder_if.sv
// Request/handshake side of the RAM responder: address, strobes and the completion/status flags.
// The 64-bit tri-state data bus stays a plain inout on the responder.
interface bus_ram_responder_if;
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic        ready;
    logic        busy;
    logic        err;

    modport slave (
        input  address, mem_read, mem_write,
        output ready, busy, err
    );

    modport master (
        output address, mem_read, mem_write,
        input  ready, busy, err
    );
endinterface

// File: rtl/bus_ram_responder.sv
// Word-addressed RAM responder on the shared LEGv8 address/data buses with programmable wait states.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned requests skip the array, flag err and read back zero.
module bus_ram_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 2
) (
    input  logic                clock,
    input  logic                reset,
    bus_ram_responder_if.slave  bus,
    inout  wire  [63:0]         data
);
    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);
    localparam logic [32:0] WIN_LO  = {1'b0, ADDR_BASE};
    localparam logic [32:0] WIN_HI  = {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) << 3);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             misal_q, misal_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [63:0]      rdata_q, rdata_d;
    logic [63:0]      mem_q [DEPTH_WORDS];

    logic             selected, req, misal_in;
    logic [IDX_W-1:0] addr_idx;
    logic             commit, commit_wr, commit_misal;
    logic [IDX_W-1:0] commit_idx;
    logic [63:0]      commit_wdata;

    // 33-bit compare so a window ending at 4 GiB does not wrap
    assign selected = ({1'b0, bus.address} >= WIN_LO) && ({1'b0, bus.address} < WIN_HI);
    assign req      = selected && (bus.mem_read ^ bus.mem_write);
    assign addr_idx = bus.address[IDX_W+2:3];

`ifdef MEM_ALIGN_CHECK_EN
    assign misal_in = |bus.address[2:0];
`else
    assign misal_in = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        misal_d      = misal_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        commit       = 1'b0;
        commit_wr    = wr_q;
        commit_misal = misal_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = bus.mem_write;
                    misal_d = misal_in;
                    idx_d   = addr_idx;
                    wdata_d = data;
                    cnt_d   = WS;
                    if (WS == 4'd0) begin
                        // no wait states: the array access happens on the acceptance edge
                        state_d      = S_DONE;
                        commit       = 1'b1;
                        commit_wr    = bus.mem_write;
                        commit_misal = misal_in;
                        commit_idx   = addr_idx;
                        commit_wdata = data;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (commit && !commit_wr)
            rdata_d = commit_misal ? 64'h0 : mem_q[commit_idx];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            misal_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 64'h0;
            rdata_q <= 64'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            misal_q <= misal_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // contents survive reset; a reset on the commit edge drops the pending write
    always_ff @(posedge clock) begin
        if (!reset && commit && commit_wr && !commit_misal)
            mem_q[commit_idx] <= commit_wdata;
    end

    assign bus.ready = (state_q == S_DONE);
    assign bus.busy  = (state_q != S_IDLE);
`ifdef MEM_ALIGN_CHECK_EN
    assign bus.err   = (state_q == S_DONE) && misal_q;
`else
    assign bus.err   = 1'b0;
`endif
    assign data = ((state_q == S_DONE) && !wr_q) ? rdata_q : 64'bz;
endmodule
